pixel_gen_pal: RTL and testbench

Parametrised successor pixel generator for the Mandelbrot VGA path. Converts the VGA timing position into a framebuffer read address, fetches the stored iteration count from the dual-port framebuffer BRAM, and maps it to an RGB colour. Mapping uses one of four modes: fixed legacy formula, writable palette, grayscale, or frame-rotating palette. All control is pipeline-aligned, so `color` matches the pixel presented three cycles earlier; the VGA sync path delays hsync/vsync by `LATENCY`.

---
 rtl/pixel_pkg.sv | 21 ++
 rtl/bram.sv | 22 ++
 rtl/pixel_gen_pal_palette_ram.sv | 22 ++
 rtl/pixel_gen_pal.sv | 159 +++++++++++++++
 tb/tb_pixel_gen_pal.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the Mandelbrot VGA pixel path: colour modes,
// default geometry and the fixed legacy colour map.
package pixel_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int LATENCY      = 3;

  typedef enum logic [1:0] {
    MODE_LEGACY  = 2'd0,
    MODE_PALETTE = 2'd1,
    MODE_GRAY    = 2'd2,
    MODE_ROTATE  = 2'd3
  } mode_e;

  // Original 4:4:4 formula, driven only by the two low iteration bits
  function automatic logic [11:0] legacy_color(input logic [1:0] d);
    return {d[1], 3'b110, 2'b01, d, d, 2'b11};
  endfunction

endpackage

// File: rtl/bram.sv
// Framebuffer: simple dual-port RAM, write port A, registered read port B,
// read-first on a same-address collision.
module bram #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_gen_pal_palette_ram.sv
// Writable colour palette: one write port, one registered read port,
// read-first so a same-index write is seen only on the next read.
module palette_ram #(
  parameter int IDX_W   = 7,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_gen_pal.sv
// VGA position -> framebuffer iteration count -> RGB, three-cycle pipeline
// with legacy, palette, grayscale and frame-rotating palette modes.
module pixel_gen_pal
  import pixel_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ITER_W   = 7,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 12,
  parameter int ROT_DIV  = 4
) (
  input  logic               CLK_100MHz,
  input  logic               reset,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               read_enable,
  input  logic               wea,
  input  logic [ADDR_W-1:0]  addr_w,
  input  logic [ITER_W-1:0]  dina,
  input  logic               pal_we,
  input  logic [ITER_W-1:0]  pal_addr,
  input  logic [COLOR_W-1:0] pal_data,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] color,
  output logic               color_valid
);

  localparam int CH    = COLOR_W / 3;
  localparam int CNT_W = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

  // stage 1: address and qualifiers
  logic [19:0]         lin_addr;
  logic                in_range;
  logic [ADDR_W-1:0]   rd_addr;
  mode_e               mode1, mode2;
  logic [LATENCY-1:0]  vld_pipe;

  assign lin_addr = 20'(pixel_y) * 20'(H_ACTIVE) + 20'(pixel_x);
  assign in_range = (32'(pixel_x) < H_ACTIVE) && (32'(pixel_y) < V_ACTIVE);

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      rd_addr  <= '0;
      mode1    <= MODE_LEGACY;
      mode2    <= MODE_LEGACY;
      vld_pipe <= '0;
    end else begin
      rd_addr  <= ADDR_W'(lin_addr);
      mode1    <= mode_e'(mode);
      mode2    <= mode1;
      vld_pipe <= {vld_pipe[LATENCY-2:0], video_on & read_enable & in_range};
    end
  end

  // stage 2: framebuffer read
  logic [ITER_W-1:0] d;

  bram #(.ADDR_W(ADDR_W), .DATA_W(ITER_W)) u_fb (
    .clk   (CLK_100MHz),
    .we    (wea),
    .waddr (addr_w),
    .wdata (dina),
    .raddr (rd_addr),
    .rdata (d)
  );

  // rotation counters, running in every mode
  logic             at_origin_q;
  logic             frame_start;
  logic [CNT_W-1:0] frame_cnt;
  logic [ITER_W-1:0] rot_off;

  assign frame_start = (pixel_x == '0) && (pixel_y == '0) && !at_origin_q;

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      at_origin_q <= 1'b0;
      frame_cnt   <= '0;
      rot_off     <= '0;
    end else begin
      at_origin_q <= (pixel_x == '0) && (pixel_y == '0);
      if (frame_start) begin
        if (frame_cnt == CNT_W'(ROT_DIV - 1)) begin
          frame_cnt <= '0;
          rot_off   <= rot_off + 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // palette lookup lands in the same edge as the stage-3 registers
  logic [ITER_W-1:0]  pal_raddr;
  logic [COLOR_W-1:0] pal_q;

  assign pal_raddr = (mode2 == MODE_ROTATE) ? d + rot_off : d;

  palette_ram #(.IDX_W(ITER_W), .COLOR_W(COLOR_W)) u_pal (
    .clk   (CLK_100MHz),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (pal_raddr),
    .rdata (pal_q)
  );

  // direct (non-palette) colour candidates
  logic [CH-1:0]      gray_ch;
  logic [COLOR_W-1:0] gray, legacy;

  if (ITER_W >= CH) begin : g_gray_top
    assign gray_ch = d[ITER_W-1 -: CH];
  end else begin : g_gray_ext
    assign gray_ch = CH'(d);
  end
  assign gray = {3{gray_ch}};

  if (COLOR_W == 12) begin : g_legacy
    assign legacy = COLOR_W'(legacy_color(d[1:0]));
  end else begin : g_legacy_gray
    assign legacy = gray;
  end

  // stage 3: output registers
  logic               sel_pal_d, sel_pal;
  logic [COLOR_W-1:0] direct_d, direct_q;

  always_comb begin
    sel_pal_d = 1'b0;
    direct_d  = '0;
    if (vld_pipe[1]) begin
      unique case (mode2)
        MODE_LEGACY:  direct_d  = legacy;
        MODE_GRAY:    direct_d  = gray;
        MODE_PALETTE,
        MODE_ROTATE:  sel_pal_d = (d != '1);
        default:      direct_d  = '0;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      sel_pal  <= 1'b0;
      direct_q <= '0;
    end else begin
      sel_pal  <= sel_pal_d;
      direct_q <= direct_d;
    end
  end

  // both mux inputs are registers and sel_pal clears on reset -> instant black
  assign color       = sel_pal ? pal_q : direct_q;
  assign color_valid = vld_pipe[LATENCY-1];

endmodule

// File: tb/tb_pixel_gen_pal.sv
// Directed bench for pixel_gen_pal: modes, blanking, rotation and reset.
module tb_pixel_gen_pal;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on, read_enable, wea, pal_we;
  logic [9:0]  pixel_x, pixel_y;
  logic [18:0] addr_w;
  logic [6:0]  dina, pal_addr;
  logic [11:0] pal_data;
  logic [1:0]  mode;
  logic [11:0] color;
  logic        color_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_gen_pal dut (
    .CLK_100MHz  (clk),
    .reset       (reset),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .read_enable (read_enable),
    .wea         (wea),
    .addr_w      (addr_w),
    .dina        (dina),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .mode        (mode),
    .color       (color),
    .color_valid (color_valid)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fb_wr(input logic [18:0] a, input logic [6:0] v);
    wea = 1'b1; addr_w = a; dina = v;
    step(1);
    wea = 1'b0;
  endtask

  task automatic pal_wr(input logic [6:0] a, input logic [11:0] v);
    pal_we = 1'b1; pal_addr = a; pal_data = v;
    step(1);
    pal_we = 1'b0;
  endtask

  task automatic px(input int x, input int y, input logic [1:0] m);
    pixel_x = 10'(x); pixel_y = 10'(y); mode = m;
  endtask

  // one rising edge of "at origin"
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pixel_x = 10'd0; pixel_y = 10'd0; step(1);
      pixel_x = 10'd1; step(1);
    end
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b0; read_enable = 1'b0; wea = 1'b0; pal_we = 1'b0;
    addr_w = '0; dina = '0; pal_addr = '0; pal_data = '0;
    px(5, 5, 2'd0);
    step(2);
    chk("reset_color", color, 12'h000);
    chk("reset_valid", {11'd0, color_valid}, 12'h001 & 12'h000);
    reset = 1'b0;
    step(1);

    // mode 0: d=3 -> R=1110 G=0111 B=1111; d=0 -> 0110 0100 0011
    fb_wr(19'd0, 7'h03);
    fb_wr(19'd2, 7'h00);
    video_on = 1'b1; read_enable = 1'b1;
    px(0, 0, 2'd0); step(3);
    chk("legacy_d3", color, 12'hE7F);
    chk("legacy_valid", {11'd0, color_valid}, 12'h001);
    px(2, 0, 2'd0); step(3);
    chk("legacy_d0", color, 12'h643);

    // mode 1
    pal_wr(7'd5, 12'hABC);
    pal_wr(7'h7F, 12'h555);
    fb_wr(19'd641, 7'd5);
    px(1, 1, 2'd1); step(3);
    chk("pal_5", color, 12'hABC);
    fb_wr(19'd641, 7'h7F);
    step(3);
    chk("pal_maxiter", color, 12'h000);
    chk("pal_maxiter_valid", {11'd0, color_valid}, 12'h001);

    // mode 2: 0x5A top nibble 1011
    fb_wr(19'd641, 7'h5A);
    px(1, 1, 2'd2); step(3);
    chk("gray_5a", color, 12'hBBB);

    // blanking
    video_on = 1'b0; step(3);
    chk("video_off_color", color, 12'h000);
    chk("video_off_valid", {11'd0, color_valid}, 12'h000);
    video_on = 1'b1; px(700, 1, 2'd2); step(3);
    chk("x700_color", color, 12'h000);
    chk("x700_valid", {11'd0, color_valid}, 12'h000);
    px(1, 1, 2'd2); step(3);
    chk("gray_restore", color, 12'hBBB);
    read_enable = 1'b0;
    step(1); chk("re_drop_c1", color, 12'hBBB);
    step(1); chk("re_drop_c2", color, 12'hBBB);
    step(1); chk("re_drop_c3", color, 12'h000);
    read_enable = 1'b1;

    // mode 3: identity palette, counters from a fresh reset
    for (int i = 0; i < 128; i++) pal_wr(7'(i), 12'(i));
    fb_wr(19'd641, 7'd2);
    reset = 1'b1; step(1); reset = 1'b0;
    px(1, 0, 2'd3);
    frames(3);
    px(1, 1, 2'd3); step(3);
    chk("rot_3frames", color, 12'h002);
    px(1, 0, 2'd3);
    frames(1);
    px(1, 1, 2'd3); step(3);
    chk("rot_4frames", color, 12'h003);

    // mode switch per pixel: 3,1,3 -> 003,002,003
    px(1, 1, 2'd3); step(1);
    px(1, 1, 2'd1); step(1);
    px(1, 1, 2'd3); step(1);
    chk("switch_m3", color, 12'h003);
    step(1); chk("switch_m1", color, 12'h002);
    step(1); chk("switch_m3b", color, 12'h003);

    // 512 frame starts in total -> offset wraps to 0
    px(1, 0, 2'd3);
    frames(508);
    px(1, 1, 2'd3); step(3);
    chk("rot_wrap", color, 12'h002);
    fb_wr(19'd641, 7'h7F);
    step(3);
    chk("rot_maxiter", color, 12'h000);
    fb_wr(19'd641, 7'd2);
    px(1, 0, 2'd3);
    frames(4);
    px(1, 1, 2'd3); step(3);
    chk("rot_again", color, 12'h003);

    // async reset mid-line
    reset = 1'b1; #1;
    chk("async_rst_color", color, 12'h000);
    chk("async_rst_valid", {11'd0, color_valid}, 12'h000);
    step(2);
    reset = 1'b0;
    chk("post_rst_v0", {11'd0, color_valid}, 12'h000);
    step(1); chk("post_rst_v1", {11'd0, color_valid}, 12'h000);
    step(1); chk("post_rst_v2", {11'd0, color_valid}, 12'h000);
    step(1); chk("post_rst_v3", {11'd0, color_valid}, 12'h001);
    chk("post_rst_rot0", color, 12'h002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
